// File: rtl/axi_rd_chop.sv
// AXI4 read slave that splits INCR bursts into memory fetches of at most CHOP_BEATS beats.
// Optional feature macro AXI_RD_SLVERR_EN: non-INCR bursts are answered with SLVERR beats instead of fetched.
module axi_rd_chop #(
    parameter int ADDRS           = 32,
    parameter int WIDTH           = 32,
    parameter int AXI_ID_WIDTH    = 4,
    parameter int CHOP_BEATS      = 4,
    parameter int PENDING         = 4,
    parameter int DATA_FIFO_DEPTH = 512
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,
    input  logic [ADDRS-1:0]        axi_araddr_i,
    input  logic [AXI_ID_WIDTH-1:0] axi_arid_i,
    input  logic [7:0]              axi_arlen_i,
    input  logic [1:0]              axi_arburst_i,
    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i,
    output logic                    axi_rlast_o,
    output logic [1:0]              axi_rresp_o,
    output logic [AXI_ID_WIDTH-1:0] axi_rid_o,
    output logic [WIDTH-1:0]        axi_rdata_o,
    output logic                    mem_fetch_o,
    input  logic                    mem_accept_i,
    output logic [ADDRS-1:0]        mem_addr_o,
    output logic [AXI_ID_WIDTH-1:0] mem_reqid_o,
    output logic [7:0]              mem_len_o,
    input  logic                    mem_valid_i,
    output logic                    mem_ready_o,
    input  logic [WIDTH-1:0]        mem_data_i
);
    localparam int TPW = (PENDING > 1) ? $clog2(PENDING) : 1;
    localparam int TCW = $clog2(PENDING) + 1;
    localparam int DPW = (DATA_FIFO_DEPTH > 1) ? $clog2(DATA_FIFO_DEPTH) : 1;
    localparam int DCW = $clog2(DATA_FIFO_DEPTH) + 1;
    localparam int BSH = $clog2(WIDTH / 8);
    localparam logic [8:0] CB9 = 9'(CHOP_BEATS);

    // state    | meaning
    // ST_IDLE  | waiting for an AR; arready follows tag FIFO space
    // ST_CHOP  | issuing memory fetches for the latched INCR burst
    // ST_ERR   | one-cycle turnaround after queueing an SLVERR burst
    typedef enum logic [1:0] {ST_IDLE, ST_CHOP, ST_ERR} state_t;

    state_t                  state_q;
    logic                    arready_q;
    logic                    mem_ready_q;
    logic [ADDRS-1:0]        addr_q;
    logic [AXI_ID_WIDTH-1:0] id_q;
    logic [7:0]              len_q;
    logic [8:0]              rem_q;
    logic [8:0]              chunk;
    logic [8:0]              rem_after;
    logic [DCW-1:0]          credit_q, credit_d;
    logic                    ar_hs, ar_err, fetch_go;

    logic [AXI_ID_WIDTH-1:0] tag_id  [PENDING];
    logic [7:0]              tag_len [PENDING];
    logic                    tag_err [PENDING];
    logic [TPW-1:0]          twr_q, trd_q;
    logic [TCW-1:0]          tcnt_q, tcnt_d;
    logic                    tag_push, tag_pop;

    logic [WIDTH-1:0]        dmem [DATA_FIFO_DEPTH];
    logic [DPW-1:0]          dwr_q, drd_q;
    logic [DCW-1:0]          dcnt_q, dcnt_d;
    logic                    data_wr, data_rd;

    logic                    head_err, rvalid, rlast, r_hs;
    logic [7:0]              beat_q;

`ifdef AXI_RD_SLVERR_EN
    assign ar_err = (axi_arburst_i != 2'b01);
`else
    logic unused_burst;
    assign ar_err       = 1'b0;
    assign unused_burst = ^axi_arburst_i;
`endif

    function automatic logic [TPW-1:0] tnext(input logic [TPW-1:0] p);
        return (p == TPW'(PENDING - 1)) ? '0 : p + TPW'(1);
    endfunction

    function automatic logic [DPW-1:0] dnext(input logic [DPW-1:0] p);
        return (p == DPW'(DATA_FIFO_DEPTH - 1)) ? '0 : p + DPW'(1);
    endfunction

    assign ar_hs       = axi_arvalid_i && arready_q;
    assign chunk       = {1'b0, len_q} + 9'd1;
    assign rem_after   = rem_q - chunk;
    assign mem_fetch_o = (state_q == ST_CHOP) && (credit_q >= DCW'(chunk));
    assign fetch_go    = mem_fetch_o && mem_accept_i;

    // Error bursts carry no data, so the R side only touches the data FIFO for memory beats.
    assign head_err = tag_err[trd_q];
    assign rvalid   = (tcnt_q != '0) && (head_err || (dcnt_q != '0));
    assign rlast    = rvalid && (beat_q == tag_len[trd_q]);
    assign r_hs     = rvalid && axi_rready_i;
    assign tag_push = ar_hs;
    assign tag_pop  = r_hs && rlast;
    assign data_wr  = mem_valid_i && mem_ready_q;
    assign data_rd  = r_hs && !head_err;

    assign tcnt_d   = tcnt_q + TCW'(tag_push) - TCW'(tag_pop);
    assign dcnt_d   = dcnt_q + DCW'(data_wr) - DCW'(data_rd);
    assign credit_d = credit_q - (fetch_go ? DCW'(chunk) : '0) + DCW'(data_rd);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            arready_q   <= 1'b0;
            mem_ready_q <= 1'b0;
            addr_q      <= '0;
            id_q        <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            credit_q    <= DCW'(DATA_FIFO_DEPTH);
            twr_q       <= '0;
            trd_q       <= '0;
            tcnt_q      <= '0;
            dwr_q       <= '0;
            drd_q       <= '0;
            dcnt_q      <= '0;
            beat_q      <= '0;
        end else begin
            credit_q    <= credit_d;
            tcnt_q      <= tcnt_d;
            dcnt_q      <= dcnt_d;
            mem_ready_q <= (dcnt_d != DCW'(DATA_FIFO_DEPTH));
            if (tag_push) twr_q <= tnext(twr_q);
            if (tag_pop)  trd_q <= tnext(trd_q);
            if (data_wr)  dwr_q <= dnext(dwr_q);
            if (data_rd)  drd_q <= dnext(drd_q);
            if (r_hs)     beat_q <= rlast ? 8'd0 : beat_q + 8'd1;

            case (state_q)
                ST_IDLE: begin
                    arready_q <= (tcnt_d != TCW'(PENDING));
                    if (ar_hs) begin
                        arready_q <= 1'b0;
                        if (ar_err) begin
                            state_q <= ST_ERR;
                        end else begin
                            state_q <= ST_CHOP;
                            addr_q  <= axi_araddr_i;
                            id_q    <= axi_arid_i;
                            rem_q   <= {1'b0, axi_arlen_i} + 9'd1;
                            len_q   <= (axi_arlen_i >= 8'(CHOP_BEATS - 1)) ?
                                       8'(CHOP_BEATS - 1) : axi_arlen_i;
                        end
                    end
                end
                ST_CHOP: begin
                    if (fetch_go) begin
                        addr_q <= addr_q + (ADDRS'(chunk) << BSH);
                        rem_q  <= rem_after;
                        len_q  <= (rem_after >= CB9) ? 8'(CHOP_BEATS - 1) : 8'(rem_after - 9'd1);
                        if (rem_after == '0) begin
                            state_q   <= ST_IDLE;
                            arready_q <= (tcnt_d != TCW'(PENDING));
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    arready_q <= (tcnt_d != TCW'(PENDING));
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (tag_push) begin
            tag_id[twr_q]  <= axi_arid_i;
            tag_len[twr_q] <= axi_arlen_i;
            tag_err[twr_q] <= ar_err;
        end
        if (data_wr) dmem[dwr_q] <= mem_data_i;
    end

    assign axi_arready_o = arready_q;
    assign axi_rvalid_o  = rvalid;
    assign axi_rlast_o   = rlast;
    assign axi_rresp_o   = (rvalid && head_err) ? 2'b10 : 2'b00;
    assign axi_rid_o     = tag_id[trd_q];
    assign axi_rdata_o   = head_err ? '0 : dmem[drd_q];
    assign mem_addr_o    = addr_q;
    assign mem_reqid_o   = id_q;
    assign mem_len_o     = len_q;
    assign mem_ready_o   = mem_ready_q;

endmodule

// File: tb/tb_axi_rd_chop.sv
// Directed bench for axi_rd_chop with a shallow data FIFO (8 beats) so credit stalls are easy to reach.
// Beat data from the memory model is the byte address of the beat, so R data is predictable per burst.
module tb_axi_rd_chop;
    localparam int CHOP  = 4;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        axi_arvalid_i = 1'b0;
    logic        axi_arready_o;
    logic [31:0] axi_araddr_i = '0;
    logic [3:0]  axi_arid_i = '0;
    logic [7:0]  axi_arlen_i = '0;
    logic [1:0]  axi_arburst_i = 2'b01;
    logic        axi_rvalid_o;
    logic        axi_rready_i = 1'b0;
    logic        axi_rlast_o;
    logic [1:0]  axi_rresp_o;
    logic [3:0]  axi_rid_o;
    logic [31:0] axi_rdata_o;
    logic        mem_fetch_o;
    logic        mem_accept_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_reqid_o;
    logic [7:0]  mem_len_o;
    logic        mem_valid_i = 1'b0;
    logic        mem_ready_o;
    logic [31:0] mem_data_i = '0;

    axi_rd_chop #(
        .ADDRS(32), .WIDTH(32), .AXI_ID_WIDTH(4), .CHOP_BEATS(CHOP),
        .PENDING(4), .DATA_FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
        .axi_araddr_i(axi_araddr_i), .axi_arid_i(axi_arid_i),
        .axi_arlen_i(axi_arlen_i), .axi_arburst_i(axi_arburst_i),
        .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i),
        .axi_rlast_o(axi_rlast_o), .axi_rresp_o(axi_rresp_o),
        .axi_rid_o(axi_rid_o), .axi_rdata_o(axi_rdata_o),
        .mem_fetch_o(mem_fetch_o), .mem_accept_i(mem_accept_i),
        .mem_addr_o(mem_addr_o), .mem_reqid_o(mem_reqid_o), .mem_len_o(mem_len_o),
        .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_data_i(mem_data_i)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] addr; logic [7:0] len; logic [3:0] id; } fetch_t;
    typedef struct { logic [31:0] data; logic [3:0] id; logic last; logic [1:0] resp; } beat_t;
    typedef struct { logic [31:0] addr; logic [7:0] len; logic [3:0] id; int nfetch; } vec_t;

    fetch_t      fetch_log[$];
    beat_t       r_log[$];
    logic [31:0] mem_q[$];
    logic        accept_en = 1'b1;
    logic        rready_en = 1'b1;
    int          total = 0;
    int          bad = 0;

    // Memory model and R monitor; inputs change here, handshakes are those the next posedge will see.
    always @(negedge clock) begin
        if (reset) begin
            mem_q.delete();
            mem_valid_i  = 1'b0;
            mem_data_i   = '0;
            mem_accept_i = 1'b0;
            axi_rready_i = 1'b0;
        end else begin
            mem_accept_i = accept_en;
            axi_rready_i = rready_en;
            mem_valid_i  = (mem_q.size() != 0);
            mem_data_i   = mem_valid_i ? mem_q[0] : '0;
            if (mem_valid_i && mem_ready_o) mem_q.delete(0);
            if (mem_fetch_o && mem_accept_i) begin
                fetch_log.push_back('{mem_addr_o, mem_len_o, mem_reqid_o});
                for (int i = 0; i <= int'(mem_len_o); i++) mem_q.push_back(mem_addr_o + 32'(4 * i));
            end
            if (axi_rvalid_o && axi_rready_i)
                r_log.push_back('{axi_rdata_o, axi_rid_o, axi_rlast_o, axi_rresp_o});
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id,
                           input logic [1:0] b);
        int n = 0;
        axi_arvalid_i = 1'b1;
        axi_araddr_i  = a;
        axi_arlen_i   = l;
        axi_arid_i    = id;
        axi_arburst_i = b;
        while (!axi_arready_o && n < 500) begin
            cyc(1);
            n++;
        end
        if (n >= 500) begin
            total++;
            bad++;
            $display("FAIL ar_timeout: got arready=0 want arready=1 within 500 cycles");
        end
        cyc(1);
        axi_arvalid_i = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int k = 0;
        while (r_log.size() < n && k < 3000) begin
            cyc(1);
            k++;
        end
        if (k >= 3000) begin
            total++;
            bad++;
            $display("FAIL r_timeout: got %0d beats want %0d", r_log.size(), n);
        end
    endtask

    task automatic check_fetches(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id,
                                 input int start);
        int rem = int'(l) + 1;
        int k = 0;
        while (rem > 0) begin
            int c;
            c = (rem > CHOP) ? CHOP : rem;
            if (start + k < fetch_log.size()) begin
                chk($sformatf("fetch%0d_addr", k), fetch_log[start + k].addr, a + 32'(16 * k));
                chk($sformatf("fetch%0d_len", k), 32'(fetch_log[start + k].len), 32'(c - 1));
                chk($sformatf("fetch%0d_id", k), 32'(fetch_log[start + k].id), 32'(id));
            end else begin
                total++;
                bad++;
                $display("FAIL fetch%0d_missing: got %0d fetches want more", k, fetch_log.size());
            end
            rem -= c;
            k++;
        end
    endtask

    task automatic check_burst(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id,
                               input logic err, input int start);
        for (int j = 0; j <= int'(l); j++) begin
            if (start + j < r_log.size()) begin
                chk($sformatf("beat%0d_data", j), r_log[start + j].data, err ? 32'h0 : a + 32'(4 * j));
                chk($sformatf("beat%0d_id", j), 32'(r_log[start + j].id), 32'(id));
                chk($sformatf("beat%0d_last", j), 32'(r_log[start + j].last), 32'(j == int'(l)));
                chk($sformatf("beat%0d_resp", j), 32'(r_log[start + j].resp), err ? 32'd2 : 32'd0);
            end else begin
                total++;
                bad++;
                $display("FAIL beat%0d_missing: got %0d beats", j, r_log.size());
            end
        end
    endtask

    task automatic clear_logs();
        fetch_log.delete();
        r_log.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish want finish before 400000");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        vecs[0] = '{32'h0000_1000, 8'd9,   4'd1,  3};
        vecs[1] = '{32'h0000_2000, 8'd0,   4'd2,  1};
        vecs[2] = '{32'h0000_3000, 8'd3,   4'd7,  1};
        vecs[3] = '{32'h0000_4000, 8'd4,   4'd4,  2};
        vecs[4] = '{32'hFFFF_FFF8, 8'd3,   4'd9,  1};
        vecs[5] = '{32'hFFFF_FFF8, 8'd7,   4'd10, 2};
        vecs[6] = '{32'h0000_0100, 8'd255, 4'd15, 64};

        // reset cycle, then released
        cyc(1);
        chk("rst_arready", 32'(axi_arready_o), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready_o), 32'd0);
        chk("rst_rvalid", 32'(axi_rvalid_o), 32'd0);
        chk("rst_rlast", 32'(axi_rlast_o), 32'd0);
        chk("rst_fetch", 32'(mem_fetch_o), 32'd0);
        reset = 1'b0;
        cyc(1);
        chk("post_rst_arready", 32'(axi_arready_o), 32'd1);
        chk("post_rst_mem_ready", 32'(mem_ready_o), 32'd1);
        chk("post_rst_rvalid", 32'(axi_rvalid_o), 32'd0);

        for (int v = 0; v < 7; v++) begin
            clear_logs();
            send_ar(vecs[v].addr, vecs[v].len, vecs[v].id, 2'b01);
            wait_beats(int'(vecs[v].len) + 1);
            cyc(2);
            chk($sformatf("vec%0d_nfetch", v), 32'(fetch_log.size()), 32'(vecs[v].nfetch));
            chk($sformatf("vec%0d_nbeats", v), 32'(r_log.size()), 32'(int'(vecs[v].len) + 1));
            check_fetches(vecs[v].addr, vecs[v].len, vecs[v].id, 0);
            check_burst(vecs[v].addr, vecs[v].len, vecs[v].id, 1'b0, 0);
        end

        // fetch held while memory refuses it
        clear_logs();
        accept_en = 1'b0;
        send_ar(32'h0000_5000, 8'd3, 4'd6, 2'b01);
        for (int i = 0; i < 5; i++) begin
            chk("stall_fetch", 32'(mem_fetch_o), 32'd1);
            chk("stall_addr", mem_addr_o, 32'h0000_5000);
            chk("stall_len", 32'(mem_len_o), 32'd3);
            chk("stall_id", 32'(mem_reqid_o), 32'd6);
            cyc(1);
        end
        chk("stall_no_accept", 32'(fetch_log.size()), 32'd0);
        accept_en = 1'b1;
        wait_beats(4);
        cyc(2);
        chk("stall_nfetch", 32'(fetch_log.size()), 32'd1);
        check_burst(32'h0000_5000, 8'd3, 4'd6, 1'b0, 0);

        // credit limit with R stalled
        clear_logs();
        rready_en = 1'b0;
        send_ar(32'h0000_6000, 8'd15, 4'd2, 2'b01);
        cyc(30);
        chk("credit_nfetch", 32'(fetch_log.size()), 32'd2);
        chk("credit_fetch_low", 32'(mem_fetch_o), 32'd0);
        chk("credit_mem_ready", 32'(mem_ready_o), 32'd0);
        chk("hold_rvalid", 32'(axi_rvalid_o), 32'd1);
        chk("hold_rdata", axi_rdata_o, 32'h0000_6000);
        cyc(3);
        chk("hold_rvalid2", 32'(axi_rvalid_o), 32'd1);
        chk("hold_rdata2", axi_rdata_o, 32'h0000_6000);
        chk("hold_rlast", 32'(axi_rlast_o), 32'd0);
        rready_en = 1'b1;
        wait_beats(16);
        cyc(2);
        chk("credit_nfetch_final", 32'(fetch_log.size()), 32'd4);
        check_fetches(32'h0000_6000, 8'd15, 4'd2, 0);
        check_burst(32'h0000_6000, 8'd15, 4'd2, 1'b0, 0);

        // back-to-back bursts
        clear_logs();
        rready_en = 1'b0;
        send_ar(32'h0000_7000, 8'd0, 4'd3, 2'b01);
        send_ar(32'h0000_8000, 8'd3, 4'd5, 2'b01);
        rready_en = 1'b1;
        wait_beats(5);
        cyc(2);
        chk("b2b_nbeats", 32'(r_log.size()), 32'd5);
        check_burst(32'h0000_7000, 8'd0, 4'd3, 1'b0, 0);
        check_burst(32'h0000_8000, 8'd3, 4'd5, 1'b0, 1);

        // WRAP burst queued behind an INCR burst
        clear_logs();
        rready_en = 1'b0;
        send_ar(32'h0000_A000, 8'd3, 4'd1, 2'b01);
        send_ar(32'h0000_9000, 8'd1, 4'd6, 2'b10);
        cyc(5);
        rready_en = 1'b1;
        wait_beats(6);
        cyc(2);
        chk("wrap_nbeats", 32'(r_log.size()), 32'd6);
        check_burst(32'h0000_A000, 8'd3, 4'd1, 1'b0, 0);
`ifdef AXI_RD_SLVERR_EN
        chk("wrap_nfetch", 32'(fetch_log.size()), 32'd1);
        check_burst(32'h0000_9000, 8'd1, 4'd6, 1'b1, 4);
`else
        chk("wrap_nfetch", 32'(fetch_log.size()), 32'd2);
        check_fetches(32'h0000_9000, 8'd1, 4'd6, 1);
        check_burst(32'h0000_9000, 8'd1, 4'd6, 1'b0, 4);
`endif

        // reset in the middle of a burst
        clear_logs();
        rready_en = 1'b0;
        send_ar(32'h0000_6000, 8'd15, 4'd2, 2'b01);
        cyc(12);
        reset = 1'b1;
        cyc(1);
        chk("mid_rst_rvalid", 32'(axi_rvalid_o), 32'd0);
        chk("mid_rst_rlast", 32'(axi_rlast_o), 32'd0);
        chk("mid_rst_fetch", 32'(mem_fetch_o), 32'd0);
        chk("mid_rst_arready", 32'(axi_arready_o), 32'd0);
        chk("mid_rst_mem_ready", 32'(mem_ready_o), 32'd0);
        reset = 1'b0;
        clear_logs();
        rready_en = 1'b1;
        cyc(10);
        chk("mid_rst_no_beats", 32'(r_log.size()), 32'd0);
        chk("mid_rst_no_fetch", 32'(fetch_log.size()), 32'd0);
        chk("mid_rst_arready_back", 32'(axi_arready_o), 32'd1);
        rready_en = 1'b0;
        send_ar(32'h0000_B000, 8'd7, 4'd8, 2'b01);
        cyc(20);
        chk("mid_rst_credit_nfetch", 32'(fetch_log.size()), 32'd2);
        rready_en = 1'b1;
        wait_beats(8);
        cyc(2);
        chk("mid_rst_nbeats", 32'(r_log.size()), 32'd8);
        check_burst(32'h0000_B000, 8'd7, 4'd8, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
